// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller, display and passcode blocks.
package alarm_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  // Passcode checker progress encoding.
  localparam logic [2:0] sIdle     = 3'd0;
  localparam logic [2:0] sDig1Corr = 3'd1;
  localparam logic [2:0] sDig2Corr = 3'd2;
  localparam logic [2:0] sDig3Corr = 3'd3;
  localparam logic [2:0] sDig4Corr = 3'd4;

endpackage

// File: rtl/second_tick_gen.sv
// One-second prescaler: tick is high on the last cycle of each CLK_HZ-cycle period.
module second_tick_gen #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Counter runs only while enabled; otherwise held at zero so each enable starts a full period.
  always_ff @(posedge clock) begin
    if (!reset || clear || !enable) cnt <= '0;
    else if (tick)                  cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm state machine with entry-delay countdown driving the display stage.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int ENTRY_DELAY_S = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm_req,
  input  logic       sensor_trip,
  input  logic [2:0] passcode_state,
  output fsm_state_t system_state,
  output logic [7:0] timer,
  output logic       siren
);

  // Display only has two decimal digits.
  if (ENTRY_DELAY_S < 1 || ENTRY_DELAY_S > 99) begin : g_bad_delay
    $error("ENTRY_DELAY_S must be within 1..99");
  end

  localparam logic [7:0] DELAY = 8'(ENTRY_DELAY_S);

  logic [2:0] pc_q;
  logic       disarm;
  logic       tick;
  logic       run;

  // Only the arrival at the final digit disarms; a held code cannot disarm again.
  assign disarm = (passcode_state == sDig4Corr) && (pc_q != sDig4Corr);
  assign run    = (system_state == STATE_TRIGGER);

  second_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (run),
    .clear  (disarm),
    .tick   (tick)
  );

  // State, countdown and siren; disarm outranks tick, tick outranks sensor and arm.
  always_ff @(posedge clock) begin
    if (!reset) begin
      system_state <= STATE_IDLE;
      timer        <= '0;
      siren        <= 1'b0;
      pc_q         <= sIdle;
    end else begin
      pc_q <= passcode_state;
      case (system_state)
        STATE_IDLE: begin
          timer <= '0;
          siren <= 1'b0;
          if (arm_req) system_state <= STATE_SET;
        end
        STATE_SET: begin
          if (disarm) begin
            system_state <= STATE_IDLE;
          end else if (sensor_trip) begin
            system_state <= STATE_TRIGGER;
            timer        <= DELAY;
          end
        end
        STATE_TRIGGER: begin
          if (disarm) begin
            system_state <= STATE_IDLE;
            timer        <= '0;
          end else if (tick) begin
            if (timer > 8'd1) begin
              timer <= timer - 8'd1;
            end else begin
              timer        <= '0;
              system_state <= STATE_ALERT;
              siren        <= 1'b1;
            end
          end
        end
        STATE_ALERT: begin
          timer <= '0;
          siren <= 1'b1;
          if (disarm) begin
            system_state <= STATE_IDLE;
            siren        <= 1'b0;
          end
        end
        default: begin
          system_state <= STATE_IDLE;
          timer        <= '0;
          siren        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with CLK_HZ=10, ENTRY_DELAY_S=3.
module tb_alarm_controller;
  import alarm_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       arm_req = 1'b0;
  logic       sensor_trip = 1'b0;
  logic [2:0] passcode_state = 3'd0;
  fsm_state_t system_state;
  logic [7:0] timer;
  logic       siren;

  int checks = 0;
  int errors = 0;

  alarm_controller #(.CLK_HZ(10), .ENTRY_DELAY_S(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .arm_req        (arm_req),
    .sensor_trip    (sensor_trip),
    .passcode_state (passcode_state),
    .system_state   (system_state),
    .timer          (timer),
    .siren          (siren)
  );

  always #5 clock = ~clock;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; arm_req = 1'b0; sensor_trip = 1'b0; passcode_state = sIdle;
    cyc(2);
    reset = 1'b1;
    checks++; if (system_state !== STATE_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", system_state, STATE_IDLE); end
    checks++; if (timer !== 8'd0) begin errors++; $display("FAIL reset_timer got %0d want 0", timer); end
    checks++; if (siren !== 1'b0) begin errors++; $display("FAIL reset_siren got %b want 0", siren); end
  endtask

  task automatic test_arm;
    arm_req = 1'b1; cyc(1); arm_req = 1'b0;
    checks++; if (system_state !== STATE_SET) begin errors++; $display("FAIL arm_state got %0d want %0d", system_state, STATE_SET); end
    checks++; if (timer !== 8'd0) begin errors++; $display("FAIL arm_timer got %0d want 0", timer); end
    checks++; if (siren !== 1'b0) begin errors++; $display("FAIL arm_siren got %b want 0", siren); end
  endtask

  task automatic test_countdown;
    sensor_trip = 1'b1; cyc(1); sensor_trip = 1'b0;
    checks++; if (system_state !== STATE_TRIGGER) begin errors++; $display("FAIL trip_state got %0d want %0d", system_state, STATE_TRIGGER); end
    checks++; if (timer !== 8'd3) begin errors++; $display("FAIL trip_timer got %0d want 3", timer); end
    cyc(9);
    checks++; if (timer !== 8'd3) begin errors++; $display("FAIL cnt9_timer got %0d want 3", timer); end
    cyc(1);
    checks++; if (timer !== 8'd2) begin errors++; $display("FAIL cnt10_timer got %0d want 2", timer); end
    cyc(10);
    checks++; if (timer !== 8'd1) begin errors++; $display("FAIL cnt20_timer got %0d want 1", timer); end
    cyc(9);
    checks++; if (system_state !== STATE_TRIGGER || timer !== 8'd1) begin errors++; $display("FAIL cnt29 got state %0d timer %0d want %0d 1", system_state, timer, STATE_TRIGGER); end
    cyc(1);
    checks++; if (timer !== 8'd0) begin errors++; $display("FAIL expiry_timer got %0d want 0", timer); end
    checks++; if (system_state !== STATE_ALERT) begin errors++; $display("FAIL expiry_state got %0d want %0d", system_state, STATE_ALERT); end
    checks++; if (siren !== 1'b1) begin errors++; $display("FAIL expiry_siren got %b want 1", siren); end
  endtask

  task automatic test_alert;
    arm_req = 1'b1; sensor_trip = 1'b1; cyc(1);
    arm_req = 1'b0; cyc(1);
    sensor_trip = 1'b0; cyc(1);
    checks++; if (system_state !== STATE_ALERT || siren !== 1'b1 || timer !== 8'd0) begin errors++; $display("FAIL alert_hold got state %0d siren %b timer %0d want %0d 1 0", system_state, siren, timer, STATE_ALERT); end
    passcode_state = sDig4Corr; cyc(1);
    checks++; if (system_state !== STATE_IDLE) begin errors++; $display("FAIL alert_disarm_state got %0d want %0d", system_state, STATE_IDLE); end
    checks++; if (siren !== 1'b0) begin errors++; $display("FAIL alert_disarm_siren got %b want 0", siren); end
    passcode_state = sIdle; cyc(1);
  endtask

  task automatic test_disarm_on_tick;
    arm_req = 1'b1; cyc(1); arm_req = 1'b0;
    sensor_trip = 1'b1; cyc(1); sensor_trip = 1'b0;
    cyc(10);
    checks++; if (timer !== 8'd2) begin errors++; $display("FAIL dt_pre_timer got %0d want 2", timer); end
    passcode_state = sDig3Corr; cyc(9);
    checks++; if (timer !== 8'd2 || system_state !== STATE_TRIGGER) begin errors++; $display("FAIL dt_pre2 got state %0d timer %0d want %0d 2", system_state, timer, STATE_TRIGGER); end
    passcode_state = sDig4Corr; cyc(1);
    checks++; if (system_state !== STATE_IDLE) begin errors++; $display("FAIL dt_state got %0d want %0d", system_state, STATE_IDLE); end
    checks++; if (timer !== 8'd0) begin errors++; $display("FAIL dt_timer got %0d want 0", timer); end
  endtask

  // passcode_state is still held at sDig4Corr on entry.
  task automatic test_held_passcode;
    arm_req = 1'b1; cyc(1); arm_req = 1'b0;
    checks++; if (system_state !== STATE_SET) begin errors++; $display("FAIL held_set got %0d want %0d", system_state, STATE_SET); end
    sensor_trip = 1'b1; cyc(1); sensor_trip = 1'b0;
    checks++; if (system_state !== STATE_TRIGGER || timer !== 8'd3) begin errors++; $display("FAIL held_trig got state %0d timer %0d want %0d 3", system_state, timer, STATE_TRIGGER); end
    cyc(3);
    checks++; if (system_state !== STATE_TRIGGER) begin errors++; $display("FAIL held_stay got %0d want %0d", system_state, STATE_TRIGGER); end
    passcode_state = sIdle; cyc(1);
    passcode_state = sDig4Corr; cyc(1);
    checks++; if (system_state !== STATE_IDLE || timer !== 8'd0) begin errors++; $display("FAIL held_redisarm got state %0d timer %0d want %0d 0", system_state, timer, STATE_IDLE); end
    passcode_state = sIdle; cyc(1);
  endtask

  task automatic test_reset_mid;
    arm_req = 1'b1; cyc(1); arm_req = 1'b0;
    sensor_trip = 1'b1; cyc(1); sensor_trip = 1'b0;
    cyc(13);
    checks++; if (timer !== 8'd2) begin errors++; $display("FAIL rm_pre_timer got %0d want 2", timer); end
    reset = 1'b0; arm_req = 1'b1; sensor_trip = 1'b1; cyc(1);
    reset = 1'b1; arm_req = 1'b0; sensor_trip = 1'b0;
    checks++; if (system_state !== STATE_IDLE || timer !== 8'd0 || siren !== 1'b0) begin errors++; $display("FAIL rm_idle got state %0d timer %0d siren %b want %0d 0 0", system_state, timer, siren, STATE_IDLE); end
    arm_req = 1'b1; cyc(1); arm_req = 1'b0;
    sensor_trip = 1'b1; cyc(1); sensor_trip = 1'b0;
    checks++; if (timer !== 8'd3) begin errors++; $display("FAIL rm_reload got %0d want 3", timer); end
    cyc(9);
    checks++; if (timer !== 8'd3) begin errors++; $display("FAIL rm_cnt9 got %0d want 3", timer); end
    cyc(1);
    checks++; if (timer !== 8'd2) begin errors++; $display("FAIL rm_cnt10 got %0d want 2", timer); end
  endtask

  initial begin
    test_reset;
    test_arm;
    test_countdown;
    test_alert;
    test_disarm_on_tick;
    test_held_passcode;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
